// File: rtl/log_antilog_acc_pkg.sv
// log_antilog_acc_pkg: shared widths and the saturating accumulate helper
package log_antilog_acc_pkg;
  localparam int LOG2_WIDTH = 4;
  localparam int WIDTH = 2**LOG2_WIDTH;
  localparam int PROD_W = 2*WIDTH;
  localparam int ACC_W = 2*WIDTH+8;
  // returns {sat, sum}; on signed overflow the sum clamps to the ACC_W max/min
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [ACC_W-1:0] val);
    logic [ACC_W:0] s;
    s = {acc[ACC_W-1], acc} + {val[ACC_W-1], val};
    return (s[ACC_W] ^ s[ACC_W-1]) ? {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : {1'b0, s[ACC_W-1:0]};
  endfunction
endpackage

// File: rtl/log_antilog_acc_if.sv
// log_antilog_acc_if: LOA-sum input beat and accumulated-result output handshakes
interface log_antilog_acc_if import log_antilog_acc_pkg::*; ();
  logic in_valid, in_ready, in_zero, in_sign, in_last;
  logic [LOG2_WIDTH:0] in_k;
  logic [WIDTH-2:0] in_x;
  logic out_valid, out_ready, out_sat;
  logic [ACC_W-1:0] out_data;
  modport master (output in_valid, in_k, in_x, in_zero, in_sign, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_sat);
  modport slave (input in_valid, in_k, in_x, in_zero, in_sign, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/log_antilog_shift.sv
// log_antilog_shift: floor(1.X * 2^K) with truncation and product-magnitude saturation
module log_antilog_shift import log_antilog_acc_pkg::*; (
  input  logic [LOG2_WIDTH:0] k,
  input  logic [WIDTH-2:0]    x,
  output logic [PROD_W-1:0]   mag,
  output logic                sat
);
  localparam int FULL_W = WIDTH + 2**(LOG2_WIDTH+1) - 1;
  logic [FULL_W-1:0] full, shr;
  logic [31:0] k_ext;
  // the top characteristic already reaches the product MSB and is treated as overflow
  always_comb begin
    k_ext = 32'(k);
    full = {{(FULL_W-WIDTH){1'b0}}, 1'b1, x} << k;
    shr = full >> (WIDTH-1);
    sat = (k_ext >= 32'(2*WIDTH-1)) | (|shr[FULL_W-1:PROD_W]);
    mag = sat ? '1 : shr[PROD_W-1:0];
  end
endmodule

// File: rtl/log_antilog_acc.sv
// log_antilog_acc: Mitchell antilog (S1) feeding a signed saturating dot-product accumulator (S2)
module log_antilog_acc import log_antilog_acc_pkg::*; (
  input logic clk,
  input logic rst,
  log_antilog_acc_if.slave bus
);
  logic [PROD_W-1:0] mag;
  logic mag_sat, stall, add_sat, beat_sat;
  logic [ACC_W-1:0] ext, sum;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_sat_q, s1_sat_d;
  logic [ACC_W-1:0] s1_val_q, s1_val_d, acc_q, acc_d, out_data_q, out_data_d;
  logic sticky_q, sticky_d, out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  log_antilog_shift u_shift (.k(bus.in_k), .x(bus.in_x), .mag(mag), .sat(mag_sat));
  // only a last beat that would overwrite an unconsumed result has to wait
  assign stall = s1_valid_q & s1_last_q & out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sat = out_sat_q;
  always_comb begin
    ext = {{(ACC_W-PROD_W){1'b0}}, mag};
    {add_sat, sum} = sat_add(acc_q, s1_val_q);
    beat_sat = add_sat | s1_sat_q;
    s1_valid_d = stall ? s1_valid_q : bus.in_valid;
    s1_last_d = stall ? s1_last_q : bus.in_last;
    s1_sat_d = stall ? s1_sat_q : mag_sat & ~bus.in_zero;
    s1_val_d = stall ? s1_val_q : bus.in_zero ? '0 : bus.in_sign ? -ext : ext;
    acc_d = acc_q;
    sticky_d = sticky_q;
    out_data_d = out_data_q;
    out_sat_d = out_sat_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    if (s1_valid_q && !stall) begin
      if (s1_last_q) begin
        out_data_d = sum;
        out_sat_d = sticky_q | beat_sat;
        out_valid_d = 1'b1;
        acc_d = '0;
        sticky_d = 1'b0;
      end else begin
        acc_d = sum;
        sticky_d = sticky_q | beat_sat;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_sat_q <= 1'b0;
      s1_val_q <= '0;
      acc_q <= '0;
      sticky_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      s1_sat_q <= s1_sat_d;
      s1_val_q <= s1_val_d;
      acc_q <= acc_d;
      sticky_q <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sat_q <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_log_antilog_acc.sv
// tb_log_antilog_acc: directed and random beats checked against an arithmetic dot-product model
module tb_log_antilog_acc;
  import log_antilog_acc_pkg::*;
  typedef struct { logic [ACC_W-1:0] d; logic s; } res_t;
  logic clk = 0, rst = 0;
  int total = 0, bad = 0, n_out = 0, n0;
  longint m_acc = 0;
  bit m_sticky = 0;
  res_t exp_q[$];
  res_t e;
  log_antilog_acc_if bus();
  log_antilog_acc dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // product = floor((2^15 + x) * 2^k / 2^15); the top characteristic counts as overflow
  function automatic void model_beat(int k, int x, bit z, bit s, bit l);
    longint mag = 0, lim = longint'(1) << (ACC_W-1);
    bit ps = 0;
    if (!z) begin
      mag = (longint'(x + (1 << (WIDTH-1))) << k) >> (WIDTH-1);
      if (k >= 2*WIDTH-1 || mag >= (longint'(1) << PROD_W)) begin
        mag = (longint'(1) << PROD_W) - 1;
        ps = 1;
      end
    end
    m_acc += s ? -mag : mag;
    if (m_acc >= lim) begin m_acc = lim - 1; ps = 1; end
    if (m_acc < -lim) begin m_acc = -lim; ps = 1; end
    m_sticky |= ps;
    if (l) begin
      exp_q.push_back('{d: m_acc[ACC_W-1:0], s: m_sticky});
      m_acc = 0;
      m_sticky = 0;
    end
  endfunction

  task automatic send(int k, int x, bit z, bit s, bit l);
    int n = 0;
    bus.in_k = 5'(k);
    bus.in_x = 15'(x);
    bus.in_zero = z;
    bus.in_sign = s;
    bus.in_last = l;
    bus.in_valid = 1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1 bus.out_ready = 1;
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $error("FAIL send_timeout in_ready=%0b expected=1", bus.in_ready);
    end else model_beat(k, x, z, s, l);
    @(posedge clk); #1 bus.in_valid = 0;
  endtask

  task automatic wait_out(string tag, logic [ACC_W-1:0] d, logic s);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_data"}, 64'(bus.out_data), 64'(d));
    chk({tag, "_sat"}, 64'(bus.out_sat), 64'(s));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) if (!rst && bus.out_valid && bus.out_ready) begin
    n_out++;
    chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_data", 64'(bus.out_data), 64'(e.d));
      chk("out_sat", 64'(bus.out_sat), 64'(e.s));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_k = '0; bus.in_x = '0; bus.in_zero = 0;
    bus.in_sign = 0; bus.in_last = 0; bus.out_ready = 1;
    #2 rst = 1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_sat", 64'(bus.out_sat), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    send(5, 0, 0, 0, 1);
    chk("lat_early_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("single_valid", 64'(bus.out_valid), 64'(1));
    chk("single_data", 64'(bus.out_data), 64'(32));
    chk("single_sat", 64'(bus.out_sat), 64'(0));
    drain();
    send(3, 'h4000, 0, 0, 1);
    send(0, 'h4000, 0, 1, 1);
    chk("frac_pos_valid", 64'(bus.out_valid), 64'(1));
    chk("frac_pos_data", 64'(bus.out_data), 64'(12));
    @(posedge clk); #1;
    chk("frac_neg_valid", 64'(bus.out_valid), 64'(1));
    chk("frac_neg_data", 64'(bus.out_data), 64'h00FF_FFFF_FFFF);
    drain();
    send(4, 0, 0, 0, 0);
    send(2, 'h2000, 0, 1, 0);
    send(31, 'h1234, 1, 1, 0);
    send(1, 0, 0, 0, 1);
    wait_out("dot", 40'd13, 0);
    drain();
    send(31, 'h7FFF, 0, 0, 1);
    wait_out("prod_sat", 40'h00FFFFFFFF, 1);
    drain();
    for (int i = 0; i < 300; i++) send(30, 'h7FFF, 0, 0, 0);
    send(0, 0, 1, 0, 1);
    wait_out("acc_sat", 40'h7FFFFFFFFF, 1);
    drain();
    n0 = n_out;
    bus.out_ready = 0;
    send(1, 0, 0, 0, 1);
    send(2, 0, 0, 0, 1);
    bus.in_k = 5'd3; bus.in_x = '0; bus.in_zero = 0; bus.in_sign = 0; bus.in_last = 1; bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_hold_data", 64'(bus.out_data), 64'(2));
    end
    @(posedge clk); #1 bus.out_ready = 1;
    send(3, 0, 0, 0, 1);
    drain();
    chk("bp_count", 64'(n_out - n0), 64'(3));
    for (int i = 0; i < 200; i++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      send($urandom_range(0, 31), $urandom_range(0, 32767), $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
    send($urandom_range(0, 20), $urandom_range(0, 32767), 0, 1'($urandom_range(0, 1)), 1);
    bus.out_ready = 1;
    drain();
    send(4, 0, 0, 0, 0);
    send(6, 0, 0, 0, 0);
    rst = 1;
    m_acc = 0;
    m_sticky = 0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1 rst = 0;
    send(5, 0, 0, 0, 1);
    wait_out("after_rst", 40'd32, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
